// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared constants and types for the instruction-fetch stage.
//               INSTR_W  - instruction width
//               PC_INC   - sequential PC step (one 32-bit word)
//               fetch_state_e - fetch FSM states (request / wait-for-data)
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam int          INSTR_W          = 32;
    localparam int          PC_INC           = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [0:0] {
        ST_REQ  = 1'b0,
        ST_WAIT = 1'b1
    } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/if_fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_stage_if
// Description : Instruction-memory request/response bus.
//               req/addr  - fetch request and word-aligned address
//               gnt       - request accepted this cycle
//               rvalid    - read data valid
//               rdata     - fetched instruction
//               master = fetch stage, slave = instruction memory.
// Revision    : 1.0 - initial release
// ============================================================================
interface if_fetch_stage_if
    import mips_pkg::*;
#(
    parameter int ADDR_W = 32
);
    logic                req;
    logic [ADDR_W-1:0]   addr;
    logic                gnt;
    logic                rvalid;
    logic [INSTR_W-1:0]  rdata;

    modport master (output req, addr, input gnt, rvalid, rdata);
    modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface
`default_nettype wire

// File: rtl/if_pc_reg.sv
`default_nettype none
// ============================================================================
// Module      : if_pc_reg
// Description : Program counter register. Redirect loads the target with the
//               low two bits cleared; otherwise the PC steps by one word when
//               a fetched instruction is accepted into the output buffer.
// Ports       : clk, rst_n          - clock, async active-low reset
//               redirect_valid/pc   - branch/jump target load
//               inc_en              - advance to the next sequential word
//               pc                  - current fetch address
// Revision    : 1.0 - initial release
// ============================================================================
module if_pc_reg
    import mips_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
)(
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              redirect_valid,
    input  wire logic [ADDR_W-1:0] redirect_pc,
    input  wire logic              inc_en,
    output logic      [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    // Redirect outranks the sequential step; the add wraps naturally.
    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = redirect_pc & ~ADDR_W'(3);
        end else if (inc_en) begin
            pc_d = pc_q + ADDR_W'(PC_INC);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule
`default_nettype wire

// File: rtl/if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_stage
// Description : Instruction-fetch stage feeding the IF/ID register. Issues one
//               outstanding fetch at a time, buffers the returned instruction
//               with its PC until decode accepts it, and handles branch/jump
//               redirect by flushing the buffer and killing any in-flight
//               response.
// Ports       : clk, rst_n               - clock, async active-low reset
//               imem (master modport)    - instruction memory bus
//               id_stall                 - decode cannot accept; hold output
//               redirect_valid/pc        - taken branch/jump and its target
//               if_valid/if_instr/if_pc  - buffered instruction to decode
//               perf_fetched/perf_stall  - only with IF_PERF_CNT_EN defined
// Options     : IF_PERF_CNT_EN - adds fetched-instruction and stall counters
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_stage
    import mips_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
)(
    input  wire logic               clk,
    input  wire logic               rst_n,
    if_fetch_stage_if.master        imem,
    input  wire logic               id_stall,
    input  wire logic               redirect_valid,
    input  wire logic [ADDR_W-1:0]  redirect_pc,
    output logic                    if_valid,
    output logic      [INSTR_W-1:0] if_instr,
    output logic      [ADDR_W-1:0]  if_pc
`ifdef IF_PERF_CNT_EN
    ,
    output logic      [31:0]        perf_fetched,
    output logic      [31:0]        perf_stall
`endif
);

    fetch_state_e       state_q, state_d;
    logic               kill_q, kill_d;
    logic               if_valid_q, if_valid_d;
    logic [INSTR_W-1:0] if_instr_q, if_instr_d;
    logic [ADDR_W-1:0]  if_pc_q, if_pc_d;

    logic [ADDR_W-1:0]  pc;
    logic               req;
    logic               req_fire;
    logic               rsp;
    logic               load;

    // Only request when the buffer will be free by the time data returns.
    // Gated by rst_n so the bus is quiet for the whole reset interval.
    assign req      = rst_n && (state_q == ST_REQ) && (!if_valid_q || !id_stall);
    assign req_fire = req && imem.gnt;
    assign rsp      = (state_q == ST_WAIT) && imem.rvalid;
    assign load     = rsp && !kill_q && !redirect_valid;

    assign imem.req  = req;
    assign imem.addr = pc;

    if_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inc_en         (load),
        .pc             (pc)
    );

    always_comb begin
        state_d    = state_q;
        kill_d     = kill_q;
        if_valid_d = if_valid_q;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;

        // Consumption first so a same-cycle response overrides it.
        if (if_valid_q && !id_stall) begin
            if_valid_d = 1'b0;
        end
        if (load) begin
            if_valid_d = 1'b1;
            if_instr_d = imem.rdata;
            if_pc_d    = pc;
        end

        case (state_q)
            ST_REQ: begin
                if (req_fire) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem.rvalid) begin
                    state_d = ST_REQ;
                    kill_d  = 1'b0;
                end
            end
            default: state_d = ST_REQ;
        endcase

        // A redirect flushes the buffer; any transaction still in flight
        // after this edge belongs to the old path and must be dropped.
        if (redirect_valid) begin
            if_valid_d = 1'b0;
            if (!rsp && ((state_q == ST_WAIT) || req_fire)) begin
                kill_d  = 1'b1;
                state_d = ST_WAIT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_REQ;
            kill_q     <= 1'b0;
            if_valid_q <= 1'b0;
            if_instr_q <= '0;
            if_pc_q    <= '0;
        end else begin
            state_q    <= state_d;
            kill_q     <= kill_d;
            if_valid_q <= if_valid_d;
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
        end
    end

    assign if_valid = if_valid_q;
    assign if_instr = if_instr_q;
    assign if_pc    = if_pc_q;

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_fetched_d = perf_fetched_q + {31'd0, load};
        perf_stall_d   = perf_stall_q + {31'd0, (if_valid_q && id_stall)};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_stall_q   <= perf_stall_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule
`default_nettype wire
